// File: rtl/mem_arbiter.sv
// Shares one single-port BRAM between two masters: fixed-priority or round-robin
// selection, starvation override, burst locking and 1-cycle read-data routing.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RR_MODE  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic              p0_lock,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy_locked,
  output logic [1:0]        dbg_state
);

  // Handshake: pN_req is a level held with stable fields until pN_ack is seen
  // high in the same cycle; that cycle the access is issued to memory.

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state_q;
  logic       last_grant_q;
  logic [7:0] wait0_q, wait1_q;
  logic [7:0] wait0_d, wait1_d;
  logic       rd_pending_q;
  logic       rd_owner_q;

  logic gnt_v;
  logic gnt_p;
  logic sel_we;
  logic starve0, starve1;

  assign starve0 = (wait0_q == MAX_WAIT_C);
  assign starve1 = (wait1_q == MAX_WAIT_C);

  always_comb begin
    gnt_v = 1'b0;
    gnt_p = 1'b0;
    case (state_q)
      LOCK0: begin
        gnt_v = p0_req;
        gnt_p = 1'b0;
      end
      LOCK1: begin
        gnt_v = p1_req;
        gnt_p = 1'b1;
      end
      default: begin
        if (p0_req && p1_req) begin
          gnt_v = 1'b1;
          // A port that alone has hit the wait limit overrides the normal policy.
          if (starve0 != starve1) gnt_p = starve1;
          else if (RR_MODE != 0)  gnt_p = ~last_grant_q;
          else                    gnt_p = 1'b1;
        end else if (p0_req) begin
          gnt_v = 1'b1;
          gnt_p = 1'b0;
        end else if (p1_req) begin
          gnt_v = 1'b1;
          gnt_p = 1'b1;
        end
      end
    endcase
  end

  assign sel_we         = gnt_p ? p1_we : p0_we;
  assign p0_ack         = gnt_v & ~gnt_p;
  assign p1_ack         = gnt_v & gnt_p;
  assign mem_write_en   = reset & gnt_v & sel_we;
  assign mem_address    = (gnt_v & gnt_p) ? p1_addr : p0_addr;
  assign mem_write_data = (gnt_v & gnt_p) ? p1_wdata : p0_wdata;

  assign p0_rdata    = mem_read_data;
  assign p1_rdata    = mem_read_data;
  assign p0_rvalid   = rd_pending_q & ~rd_owner_q;
  assign p1_rvalid   = rd_pending_q & rd_owner_q;
  assign busy_locked = (state_q != UNLOCKED);
  assign dbg_state   = state_q;

  always_comb begin
    wait0_d = wait0_q;
    wait1_d = wait1_q;
    if (!p0_req || p0_ack)    wait0_d = 8'd0;
    else if (!starve0)        wait0_d = wait0_q + 8'd1;
    if (!p1_req || p1_ack)    wait1_d = 8'd0;
    else if (!starve1)        wait1_d = wait1_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= UNLOCKED;
      last_grant_q <= 1'b1;
      wait0_q      <= 8'd0;
      wait1_q      <= 8'd0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      if (gnt_v) last_grant_q <= gnt_p;
      wait0_q      <= wait0_d;
      wait1_q      <= wait1_d;
      rd_pending_q <= gnt_v & ~sel_we;
      rd_owner_q   <= gnt_p;
      case (state_q)
        UNLOCKED: begin
          if (p0_ack && p0_lock)      state_q <= LOCK0;
          else if (p1_ack && p1_lock) state_q <= LOCK1;
        end
        LOCK0: begin
          // Dropping the request releases the lock so the other port cannot deadlock.
          if (!p0_req || (p0_ack && !p0_lock)) state_q <= UNLOCKED;
        end
        LOCK1: begin
          if (!p1_req || (p1_ack && !p1_lock)) state_q <= UNLOCKED;
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance driven by
// random requesters, each compared every cycle with a rule-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // index [inst][port]; inst 0 = round-robin (MAX_WAIT 3), inst 1 = fixed (MAX_WAIT 4)
  logic          req   [2][2];
  logic          we    [2][2];
  logic          lock  [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic          rvalid[2][2];
  logic [DW-1:0] rdata [2][2];
  logic [AW-1:0] m_addr  [2];
  logic          m_we    [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rdata [2];
  logic          busy    [2];
  logic [1:0]    dbg     [2];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_WAIT(3)) u_rr (
    .clk(clk), .reset(reset),
    .p0_req(req[0][0]), .p1_req(req[0][1]), .p0_we(we[0][0]), .p1_we(we[0][1]),
    .p0_lock(lock[0][0]), .p1_lock(lock[0][1]), .p0_addr(addr[0][0]), .p1_addr(addr[0][1]),
    .p0_wdata(wdata[0][0]), .p1_wdata(wdata[0][1]), .p0_ack(ack[0][0]), .p1_ack(ack[0][1]),
    .p0_rvalid(rvalid[0][0]), .p1_rvalid(rvalid[0][1]), .p0_rdata(rdata[0][0]), .p1_rdata(rdata[0][1]),
    .mem_address(m_addr[0]), .mem_write_en(m_we[0]), .mem_write_data(m_wdata[0]),
    .mem_read_data(m_rdata[0]), .busy_locked(busy[0]), .dbg_state(dbg[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_WAIT(4)) u_fp (
    .clk(clk), .reset(reset),
    .p0_req(req[1][0]), .p1_req(req[1][1]), .p0_we(we[1][0]), .p1_we(we[1][1]),
    .p0_lock(lock[1][0]), .p1_lock(lock[1][1]), .p0_addr(addr[1][0]), .p1_addr(addr[1][1]),
    .p0_wdata(wdata[1][0]), .p1_wdata(wdata[1][1]), .p0_ack(ack[1][0]), .p1_ack(ack[1][1]),
    .p0_rvalid(rvalid[1][0]), .p1_rvalid(rvalid[1][1]), .p0_rdata(rdata[1][0]), .p1_rdata(rdata[1][1]),
    .mem_address(m_addr[1]), .mem_write_en(m_we[1]), .mem_write_data(m_wdata[1]),
    .mem_read_data(m_rdata[1]), .busy_locked(busy[1]), .dbg_state(dbg[1])
  );

  // BRAM stand-ins: 16 words, 1-cycle read latency
  logic [DW-1:0] bram [2][16] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_we[i]) bram[i][m_addr[i][5:2]] <= m_wdata[i];
      m_rdata[i] <= bram[i][m_addr[i][5:2]];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  int            m_lock [2];     // -1 = unlocked, else owning port
  bit            m_last [2];
  int            m_w    [2][2];
  bit            m_rdp  [2];
  bit            m_rdo  [2];
  logic [DW-1:0] gold   [2][16] = '{default: '0};
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  bit            e_ack  [2][2];
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic int max_wait_of(input int i);
    return (i == 0) ? 3 : 4;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lock[i] = -1;
      m_last[i] = 1'b1;
      m_w[i][0] = 0;
      m_w[i][1] = 0;
      m_rdp[i]  = 1'b0;
      m_rdo[i]  = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic winner(input int i, output bit v, output bit p);
    bit s0, s1;
    v = 1'b0;
    p = 1'b0;
    s0 = (m_w[i][0] == max_wait_of(i));
    s1 = (m_w[i][1] == max_wait_of(i));
    if (m_lock[i] >= 0) begin
      p = (m_lock[i] == 1);
      v = req[i][p];
    end else if (req[i][0] && req[i][1]) begin
      v = 1'b1;
      if (s0 != s1)   p = s1;
      else if (i == 0) p = !m_last[i];
      else             p = 1'b1;
    end else if (req[i][0] || req[i][1]) begin
      v = 1'b1;
      p = req[i][1];
    end
  endtask

  task automatic update(input int i, input bit v, input bit p);
    logic [3:0] idx;
    idx = addr[i][p][5:2];
    for (int q = 0; q < 2; q++) begin
      if (!req[i][q] || (v && (p == q))) m_w[i][q] = 0;
      else if (m_w[i][q] < max_wait_of(i)) m_w[i][q]++;
    end
    if (v) m_last[i] = p;
    m_rdp[i] = v && !we[i][p];
    m_rdo[i] = p;
    if (v && !we[i][p]) begin
      if (i == 0) exp_q0.push_back(gold[i][idx]);
      else        exp_q1.push_back(gold[i][idx]);
    end
    if (v && we[i][p]) gold[i][idx] = wdata[i][p];
    if (m_lock[i] < 0) begin
      if (v && lock[i][p]) m_lock[i] = p;
    end else if (!req[i][m_lock[i]] || !lock[i][m_lock[i]]) begin
      m_lock[i] = -1;
    end
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(input string ph);
    #1;
    for (int i = 0; i < 2; i++) begin
      bit v, p;
      logic [DW-1:0] ed;
      winner(i, v, p);
      e_ack[i][0] = v && !p;
      e_ack[i][1] = v && p;
      check($sformatf("%s/i%0d/ack0", ph, i), 32'(ack[i][0]), 32'(v && !p));
      check($sformatf("%s/i%0d/ack1", ph, i), 32'(ack[i][1]), 32'(v && p));
      check($sformatf("%s/i%0d/mem_we", ph, i), 32'(m_we[i]), 32'(reset && v && we[i][p]));
      check($sformatf("%s/i%0d/mem_addr", ph, i), m_addr[i], (v && p) ? addr[i][1] : addr[i][0]);
      if (v && we[i][p])
        check($sformatf("%s/i%0d/mem_wdata", ph, i), m_wdata[i], wdata[i][p]);
      check($sformatf("%s/i%0d/busy", ph, i), 32'(busy[i]), 32'(m_lock[i] >= 0));
      check($sformatf("%s/i%0d/rvalid0", ph, i), 32'(rvalid[i][0]), 32'(m_rdp[i] && !m_rdo[i]));
      check($sformatf("%s/i%0d/rvalid1", ph, i), 32'(rvalid[i][1]), 32'(m_rdp[i] && m_rdo[i]));
      if (m_rdp[i]) begin
        ed = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("%s/i%0d/rdata", ph, i), rdata[i][m_rdo[i]], ed);
      end
      if (reset) update(i, v, p);
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_all(input int p, input bit r, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < 2; i++) begin
      req[i][p]   = r;
      we[i][p]    = w;
      lock[i][p]  = l;
      addr[i][p]  = a;
      wdata[i][p] = d;
    end
  endtask

  // New fields only once the previous request was acked (or the port was idle).
  task automatic rand_cycle(input int d0, input int d1, input int l0, input int l1);
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[i][p] || e_ack[i][p]) begin
          req[i][p]   = $urandom_range(0, 99) < ((p == 0) ? d0 : d1);
          we[i][p]    = 1'($urandom_range(0, 1));
          lock[i][p]  = $urandom_range(0, 99) < ((p == 0) ? l0 : l1);
          addr[i][p]  = AW'($urandom_range(0, 15)) << 2;
          wdata[i][p] = $urandom;
        end
      end
    end
  endtask

  task automatic run_phase(input string ph, input int n, input int d0, input int d1,
                           input int l0, input int l1);
    for (int k = 0; k < n; k++) begin
      rand_cycle(d0, d1, l0, l1);
      step(ph);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    model_reset();
    set_all(0, 0, 0, 0, '0, '0);
    set_all(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      e_ack[i][0] = 1'b0;
      e_ack[i][1] = 1'b0;
    end
    @(negedge clk);
    step("rst");
    set_all(0, 1, 1, 0, 32'h10, 32'h1);
    step("rst_we");
    set_all(0, 0, 0, 0, '0, '0);
    reset = 1'b1;
    step("idle");

    // word 0x10 <= DEADBEEF, then a lone port-0 read of it
    set_all(1, 1, 1, 0, 32'h10, 32'hDEADBEEF);
    step("p1wr");
    set_all(1, 0, 0, 0, '0, '0);
    set_all(0, 1, 0, 0, 32'h10, '0);
    step("p0rd");
    set_all(0, 0, 0, 0, '0, '0);
    step("p0rd_rv");

    run_phase("both",   60, 100, 100, 0, 0);
    run_phase("lock1", 300, 100, 100, 0, 70);
    run_phase("lock0", 300,  60, 100, 90, 0);
    run_phase("rand", 3000,  70,  70, 30, 30);

    // reset arrives the cycle after a port-0 read is issued
    set_all(0, 0, 0, 0, '0, '0);
    set_all(1, 0, 0, 0, '0, '0);
    step("pre_rst");
    set_all(0, 1, 0, 0, 32'h20, '0);
    step("rst_rd");
    reset = 1'b0;
    model_reset();
    set_all(0, 1, 1, 0, 32'h24, 32'h55);
    set_all(1, 1, 0, 0, 32'h28, '0);
    step("rst_mid");
    reset = 1'b1;
    set_all(0, 1, 0, 0, 32'h24, '0);
    step("post_rst");
    set_all(0, 0, 0, 0, '0, '0);
    set_all(1, 0, 0, 0, '0, '0);
    step("drain");
    step("drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
